laser_fire_arbiter: RTL and testbench

Shares the single laser emitter between `N_REQ` button requesters. It grants one requester at a time in round-robin order and drives `fire` for a fixed shot length. After each shot it enforces a cooldown. The block sits between the debounced button inputs and the emitter's `laser` enable input.

---
 rtl/laser_fire_arbiter.sv | 132 +++++++++++++
 tb/tb_laser_fire_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/laser_fire_arbiter.sv
// rtl/laser_fire_arbiter.sv - round-robin shared laser emitter arbiter with shot length and cooldown
// Optional feature macro: LASER_ARB_RELEASE_ABORT_EN (owner releasing its button aborts the shot)
module laser_fire_arbiter #(
  parameter int N_REQ       = 4,
  parameter int FIRE_CYCLES = 50_000_000,
  parameter int COOL_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             fire,
  output logic             busy
);

  localparam int CNT_MAX = (FIRE_CYCLES > COOL_CYCLES) ? FIRE_CYCLES : COOL_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CW-1:0] FIRE_LAST = CW'(FIRE_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_COOL = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic             r_fire, w_fire_nxt;
  logic             r_busy, w_busy_nxt;

  logic [PW-1:0]    w_win;
  logic             w_found;
  logic [PW:0]      w_sum;
  logic             w_abort;

  // Scan upward from the pointer with wrap-around; sum stays below 2*N_REQ.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N_REQ)) begin
        w_sum = w_sum - (PW+1)'(N_REQ);
      end
      if (!w_found && req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
  end

`ifdef LASER_ARB_RELEASE_ABORT_EN
  assign w_abort = ((req & r_grant) == '0);
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_fire_nxt  = r_fire;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_FIRE;
          w_cnt_nxt   = '0;
          w_grant_nxt = N_REQ'(1) << w_win;
          w_fire_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
        end
      end
      S_FIRE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == FIRE_LAST || w_abort) begin
          w_state_nxt = S_COOL;
          w_cnt_nxt   = '0;
          w_grant_nxt = '0;
          w_fire_nxt  = 1'b0;
        end
      end
      S_COOL: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == COOL_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_grant_nxt = '0;
        w_fire_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_fire  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_fire  <= w_fire_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign grant = r_grant;
  assign fire  = r_fire;
  assign busy  = r_busy;

endmodule

// File: tb/tb_laser_fire_arbiter.sv
// tb/tb_laser_fire_arbiter.sv - randomized and directed bench for laser_fire_arbiter against a shot-budget model
module tb_laser_fire_arbiter;

  localparam int N = 4;
  localparam int F = 4;
  localparam int C = 3;
`ifdef LASER_ARB_RELEASE_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         fire;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles of the current shot still to run (fire + cool), owner, pointer.
  int m_rem   = 0;
  int m_owner = 0;
  int m_ptr   = 0;

  laser_fire_arbiter #(
    .N_REQ      (N),
    .FIRE_CYCLES(F),
    .COOL_CYCLES(C)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .grant(grant),
    .fire (fire),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, obs=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    if (rst) begin
      m_rem = 0;
      m_ptr = 0;
    end else if (m_rem == 0) begin
      if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_ptr = (m_owner + 1) % N;
        m_rem = F + C;
      end
    end else if (ABORT && m_rem > C && !r[m_owner]) begin
      m_rem = C;
    end else begin
      m_rem = m_rem - 1;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_grant;
    exp_grant = (m_rem > C) ? (N'(1) << m_owner) : '0;
    check("grant", 32'(grant), 32'(exp_grant));
    check("fire", 32'(fire), 32'(m_rem > C));
    check("busy", 32'(busy), 32'(m_rem > 0));
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_outputs();
  endtask

  // Called at a negedge: reset must clear outputs without any clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_fire", 32'(fire), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    m_rem = 0;
    m_ptr = 0;
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b1;
    req = 4'b1111;

    for (int i = 0; i < 3; i++) step(4'b1111);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step(4'b1111);

    for (int i = 0; i < 10; i++) step(4'b0000);
    step(4'b0100);
    for (int i = 0; i < 12; i++) step(4'b0000);

    for (int i = 0; i < 18; i++) step(4'b1001);
    for (int i = 0; i < 10; i++) step(4'b0000);

    step(4'b0010);
    for (int i = 0; i < 4; i++) step(4'b0000);
    step(4'b1111);
    step(4'b0000);
    step(4'b0110);
    for (int i = 0; i < 8; i++) step(4'b0000);

    step(4'b0001);
    step(4'b0001);
    async_reset();
    step(4'b0010);
    step(4'b0010);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(4'b0010);
    for (int i = 0; i < 10; i++) step(4'b0000);

    step(4'b0001);
    step(4'b0001);
    for (int i = 0; i < 10; i++) step(4'b0000);

    r = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = ($urandom_range(0, 4) == 0) ? 4'b0000 : N'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        step(r);
        rst = 1'b0;
      end
      step(r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
